// File: rtl/qec_grid_decoder.sv
// Stabiliser-grid decoder: a GRID_ROWS x GRID_COLS mesh of pe nodes driven by a one-shot decode controller.
// Defining QEC_GRID_CYCLE_COUNT_EN adds the cycle_count output (RUN length of the last decode).

module pe #(
    parameter int ROW_ID            = 0,
    parameter int COL_ID            = 0,
    parameter int BOUNDARY_COST     = 1,
    parameter int MSG_WIDTH         = 8,
    parameter int MATCH_VALUE_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           measurement_in,
    input  logic                           measurement_valid_in,
    input  logic                           start_offer,
    input  logic                           stop_offer,
    input  logic [3:0][MSG_WIDTH-1:0]      mailbox_value_in,
    input  logic [3:0]                     mailbox_valid_in,
    output logic [3:0]                     mailbox_ready_out,
    output logic [3:0][MSG_WIDTH-1:0]      outqueue_value_out,
    output logic [3:0]                     outqueue_valid_out,
    input  logic [3:0]                     outqueue_ready_in,
    output logic [MATCH_VALUE_WIDTH-1:0]   match_value_out
);
    // Directions are indexed N=0, E=1, S=2, W=3; a match value of 0 means unmatched.
    localparam logic [MSG_WIDTH-1:0] SELF_ID = MSG_WIDTH'(ROW_ID * 16 + COL_ID + 1);
    localparam logic [MATCH_VALUE_WIDTH-1:0] BOUNDARY_MATCH =
        {1'b1, (MATCH_VALUE_WIDTH-1)'(BOUNDARY_COST)};

    logic                         r_defect;
    logic [3:0]                   r_pending;
    logic [MATCH_VALUE_WIDTH-1:0] r_match;
    logic                         w_hit;
    logic [MSG_WIDTH-1:0]         w_msg;

    always_comb begin
        w_hit = 1'b0;
        w_msg = {MSG_WIDTH{1'b0}};
        for (int d = 3; d >= 0; d--) begin
            w_hit = w_hit | mailbox_valid_in[d];
            w_msg = mailbox_valid_in[d] ? mailbox_value_in[d] : w_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_defect  <= 1'b0;
            r_pending <= 4'b0000;
            r_match   <= {MATCH_VALUE_WIDTH{1'b0}};
        end else if (measurement_valid_in) begin
            r_defect  <= measurement_in;
            r_pending <= 4'b0000;
            r_match   <= {MATCH_VALUE_WIDTH{1'b0}};
        end else begin
            r_pending <= start_offer ? {4{r_defect}} : (r_pending & ~outqueue_ready_in);
            if (r_defect && (r_match == {MATCH_VALUE_WIDTH{1'b0}}) && w_hit) begin
                r_match <= MATCH_VALUE_WIDTH'(w_msg);
            end else if (stop_offer && r_defect && (r_match == {MATCH_VALUE_WIDTH{1'b0}})) begin
                // An offer nobody answered is matched to the boundary.
                r_match <= BOUNDARY_MATCH;
            end
        end
    end

    assign mailbox_ready_out  = 4'b1111;
    assign outqueue_valid_out = r_pending;
    assign outqueue_value_out = {4{SELF_ID}};
    assign match_value_out    = r_match;
endmodule

module qec_grid_decoder #(
    parameter int GRID_ROWS         = 2,
    parameter int GRID_COLS         = 3,
    parameter int BOUNDARY_COST     = 1,
    parameter int QUIET_CYCLES      = 4,
    parameter int MAX_CYCLES        = 1024,
    parameter int CNT_W             = 16,
    parameter int MSG_WIDTH         = 8,
    parameter int MATCH_VALUE_WIDTH = 8
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             start_valid,
    output logic                                             start_ready,
    input  logic [GRID_ROWS*GRID_COLS-1:0]                   syndrome_in,
    output logic                                             result_valid,
    input  logic                                             result_ready,
    output logic [GRID_ROWS*GRID_COLS*MATCH_VALUE_WIDTH-1:0] match_values_out,
    output logic                                             timed_out,
`ifdef QEC_GRID_CYCLE_COUNT_EN
    output logic [CNT_W-1:0]                                 cycle_count,
`endif
    output logic                                             busy
);
    localparam int NPE = GRID_ROWS * GRID_COLS;
    localparam int MVW = MATCH_VALUE_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_OFFER, S_RUN, S_STOP, S_CAPTURE, S_DONE} state_t;

    state_t                    r_state, w_next;
    logic [NPE-1:0]            r_syndrome;
    logic [CNT_W-1:0]          r_run_cnt, r_quiet_cnt;
    logic                      r_timeout;
    logic [NPE*MVW-1:0]        r_match_values;
    logic [3:0][MSG_WIDTH-1:0] w_oq_value [NPE];
    logic [3:0]                w_oq_valid [NPE];
    logic [3:0]                w_mb_ready [NPE];
    logic [NPE-1:0]            w_link_act;
    logic [NPE*MVW-1:0]        w_match_flat;
    logic                      w_activity, w_load, w_start_offer, w_stop_offer;
    logic                      w_quiet_done, w_run_done;

    for (genvar r = 0; r < GRID_ROWS; r++) begin : g_row
        for (genvar c = 0; c < GRID_COLS; c++) begin : g_col
            localparam int K  = r * GRID_COLS + c;
            localparam int KN = (r > 0) ? K - GRID_COLS : K;
            localparam int KE = (c < GRID_COLS - 1) ? K + 1 : K;
            localparam int KS = (r < GRID_ROWS - 1) ? K + GRID_COLS : K;
            localparam int KW = (c > 0) ? K - 1 : K;
            // Bit d set when direction d leads to a neighbour rather than an open edge.
            localparam logic [3:0] LINKS = {c > 0, r < GRID_ROWS - 1, c < GRID_COLS - 1, r > 0};

            logic [3:0][MSG_WIDTH-1:0] w_mb_value;
            logic [3:0]                w_mb_valid, w_oq_ready;

            assign w_mb_value = {LINKS[3] ? w_oq_value[KW][1] : {MSG_WIDTH{1'b0}},
                                 LINKS[2] ? w_oq_value[KS][0] : {MSG_WIDTH{1'b0}},
                                 LINKS[1] ? w_oq_value[KE][3] : {MSG_WIDTH{1'b0}},
                                 LINKS[0] ? w_oq_value[KN][2] : {MSG_WIDTH{1'b0}}};
            assign w_mb_valid = {LINKS[3] & w_oq_valid[KW][1], LINKS[2] & w_oq_valid[KS][0],
                                 LINKS[1] & w_oq_valid[KE][3], LINKS[0] & w_oq_valid[KN][2]};
            assign w_oq_ready = {LINKS[3] ? w_mb_ready[KW][1] : 1'b1, LINKS[2] ? w_mb_ready[KS][0] : 1'b1,
                                 LINKS[1] ? w_mb_ready[KE][3] : 1'b1, LINKS[0] ? w_mb_ready[KN][2] : 1'b1};
            assign w_link_act[K] = |(w_oq_valid[K] & LINKS);

            pe #(
                .ROW_ID(r), .COL_ID(c), .BOUNDARY_COST(BOUNDARY_COST),
                .MSG_WIDTH(MSG_WIDTH), .MATCH_VALUE_WIDTH(MVW)
            ) u_pe (
                .clk(clk), .reset(reset),
                .measurement_in(r_syndrome[K]), .measurement_valid_in(w_load),
                .start_offer(w_start_offer), .stop_offer(w_stop_offer),
                .mailbox_value_in(w_mb_value), .mailbox_valid_in(w_mb_valid),
                .mailbox_ready_out(w_mb_ready[K]),
                .outqueue_value_out(w_oq_value[K]), .outqueue_valid_out(w_oq_valid[K]),
                .outqueue_ready_in(w_oq_ready),
                .match_value_out(w_match_flat[K*MVW +: MVW])
            );
        end
    end

    assign w_activity   = |w_link_act;
    assign w_quiet_done = !w_activity && (r_quiet_cnt == CNT_W'(QUIET_CYCLES - 1));
    assign w_run_done   = (r_run_cnt == CNT_W'(MAX_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_load        = 1'b0;
        w_start_offer = 1'b0;
        w_stop_offer  = 1'b0;
        case (r_state)
            S_IDLE:    w_next = start_valid ? S_LOAD : S_IDLE;
            S_LOAD:    begin w_load = 1'b1; w_next = S_OFFER; end
            S_OFFER:   begin w_start_offer = 1'b1; w_next = S_RUN; end
            // Quiescence is tested first so it wins a tie with the cycle limit.
            S_RUN:     w_next = (w_quiet_done || w_run_done) ? S_STOP : S_RUN;
            S_STOP:    begin w_stop_offer = 1'b1; w_next = S_CAPTURE; end
            S_CAPTURE: w_next = S_DONE;
            S_DONE:    w_next = result_ready ? S_IDLE : S_DONE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_syndrome     <= {NPE{1'b0}};
            r_run_cnt      <= {CNT_W{1'b0}};
            r_quiet_cnt    <= {CNT_W{1'b0}};
            r_timeout      <= 1'b0;
            r_match_values <= {(NPE*MVW){1'b0}};
        end else begin
            case (r_state)
                S_IDLE: if (start_valid) r_syndrome <= syndrome_in;
                S_OFFER: begin
                    r_run_cnt   <= {CNT_W{1'b0}};
                    r_quiet_cnt <= {CNT_W{1'b0}};
                    r_timeout   <= 1'b0;
                end
                S_RUN: begin
                    r_run_cnt   <= r_run_cnt + CNT_W'(1);
                    r_quiet_cnt <= w_activity ? {CNT_W{1'b0}} : r_quiet_cnt + CNT_W'(1);
                    if (!w_quiet_done && w_run_done) r_timeout <= 1'b1;
                end
                S_CAPTURE: r_match_values <= w_match_flat;
                default: ;
            endcase
        end
    end

`ifdef QEC_GRID_CYCLE_COUNT_EN
    logic [CNT_W-1:0] r_cycle_count;

    // RUN length of the most recent decode, held until the next capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count <= {CNT_W{1'b0}};
        end else if (r_state == S_CAPTURE) begin
            r_cycle_count <= r_run_cnt;
        end
    end

    assign cycle_count = r_cycle_count;
`else
    // Without the option the run counter only steers the controller.
`endif

    assign start_ready      = (r_state == S_IDLE);
    assign busy             = (r_state != S_IDLE);
    assign result_valid     = (r_state == S_DONE);
    assign timed_out        = (r_state == S_DONE) && r_timeout;
    assign match_values_out = r_match_values;
endmodule
